// File: rtl/wam_pkg.sv
// Shared state codes, blink phase type and glyph codes for the score display.
// The game FSM drives the same ST_* codes on its state output.
package wam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GAMEPLAY = 3'd1,
    ST_END      = 3'd2,
    ST_CODE3    = 3'd3,
    ST_CODE4    = 3'd4,
    ST_CODE5    = 3'd5,
    ST_CODE6    = 3'd6,
    ST_CODE7    = 3'd7
  } wam_state_e;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_e;

  // Glyph codes 0..15 are the hex digits themselves; letters reuse A and E.
  typedef logic [4:0] glyph_t;

  localparam glyph_t GL_A     = 5'd10;
  localparam glyph_t GL_E     = 5'd14;
  localparam glyph_t GL_P     = 5'd16;
  localparam glyph_t GL_L     = 5'd17;
  localparam glyph_t GL_Y     = 5'd18;
  localparam glyph_t GL_DASH  = 5'd19;
  localparam glyph_t GL_BLANK = 5'd20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic glyph_t hex_glyph(input logic [3:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Glyph code to active-low segment pattern {g,f,e,d,c,b,a}.
// Unused codes render blank.
module seg7_glyph
  import wam_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (glyph)
      5'd0:    seg_n = 7'h40;
      5'd1:    seg_n = 7'h79;
      5'd2:    seg_n = 7'h24;
      5'd3:    seg_n = 7'h30;
      5'd4:    seg_n = 7'h19;
      5'd5:    seg_n = 7'h12;
      5'd6:    seg_n = 7'h02;
      5'd7:    seg_n = 7'h78;
      5'd8:    seg_n = 7'h00;
      5'd9:    seg_n = 7'h10;
      GL_A:    seg_n = 7'h08;
      5'd11:   seg_n = 7'h03;
      5'd12:   seg_n = 7'h46;
      5'd13:   seg_n = 7'h21;
      GL_E:    seg_n = 7'h06;
      5'd15:   seg_n = 7'h0E;
      GL_P:    seg_n = 7'h0C;
      GL_L:    seg_n = 7'h47;
      GL_Y:    seg_n = 7'h11;
      GL_DASH: seg_n = 7'h3F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/wam_score_display.sv
// 4-digit multiplexed 7-seg driver for the game's score/lives/state outputs.
// Define WAM_DISP_BLINK_EN to blink the END_SCREEN.
module wam_score_display
  import wam_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score,
  input  logic [3:0] lives,
  input  logic [2:0] state,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  if (REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("wam_score_display: REFRESH_DIV and BLINK_DIV must be >= 1");
  end

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             boot_q, boot_d;
  logic [3:0]       score_lat_q, score_lat_d;
  logic [3:0]       lives_lat_q, lives_lat_d;
  wam_state_e       state_lat_q, state_lat_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             ref_tc;
  logic             frame_latch;
  logic             score_tens;
  logic [3:0]       score_units;
  glyph_t           tens_glyph;
  glyph_t           glyph_sel;
  logic [6:0]       seg_raw;
  logic             blink_hide;

  // Scan timing and frame latch; inputs are only sampled at frame boundaries
  // so a mid-frame change never tears the display.
  always_comb begin
    ref_tc      = (ref_cnt_q == REF_LAST);
    ref_cnt_d   = ref_tc ? '0 : ref_cnt_q + 1'b1;
    idx_d       = ref_tc ? idx_q + 2'd1 : idx_q;
    frame_latch = boot_q || (ref_tc && (idx_q == 2'd3));
    boot_d      = 1'b0;
    score_lat_d = score_lat_q;
    lives_lat_d = lives_lat_q;
    state_lat_d = state_lat_q;
    if (frame_latch) begin
      score_lat_d = score;
      lives_lat_d = lives;
      state_lat_d = wam_state_e'(state);
    end
  end

  always_comb begin
    score_tens  = (score_lat_q >= 4'd10);
    score_units = score_tens ? score_lat_q - 4'd10 : score_lat_q;
    tens_glyph  = score_tens ? hex_glyph(4'd1) : GL_BLANK;
    glyph_sel   = GL_DASH;
    case (state_lat_q)
      ST_IDLE: begin
        case (idx_q)
          2'd0:    glyph_sel = GL_Y;
          2'd1:    glyph_sel = GL_A;
          2'd2:    glyph_sel = GL_L;
          default: glyph_sel = GL_P;
        endcase
      end
      ST_GAMEPLAY: begin
        case (idx_q)
          2'd0:    glyph_sel = hex_glyph(score_units);
          2'd1:    glyph_sel = tens_glyph;
          2'd2:    glyph_sel = hex_glyph(lives_lat_q);
          default: glyph_sel = GL_L;
        endcase
      end
      ST_END: begin
        case (idx_q)
          2'd0:    glyph_sel = hex_glyph(score_units);
          2'd1:    glyph_sel = tens_glyph;
          2'd2:    glyph_sel = GL_BLANK;
          default: glyph_sel = GL_E;
        endcase
      end
      default: glyph_sel = GL_DASH;
    endcase
  end

  seg7_glyph u_glyph (
    .glyph (glyph_sel),
    .seg_n (seg_raw)
  );

`ifdef WAM_DISP_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e     phase_q, phase_d;

  // Counter idles at zero/visible outside END_SCREEN, so entry always starts fresh.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = PH_VISIBLE;
    if (state_lat_q == ST_END) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= PH_VISIBLE;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_hide = (phase_q == PH_HIDDEN) && (state_lat_q == ST_END);
`else
  assign blink_hide = 1'b0;
`endif

  always_comb begin
    an_d  = blink_hide ? '1 : ~(4'b0001 << idx_q);
    seg_d = blink_hide ? SEG_BLANK : seg_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      boot_q      <= 1'b1;
      score_lat_q <= '0;
      lives_lat_q <= '0;
      state_lat_q <= ST_IDLE;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      boot_q      <= boot_d;
      score_lat_q <= score_lat_d;
      lives_lat_q <= lives_lat_d;
      state_lat_q <= state_lat_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_wam_score_display.sv
// Self-checking bench for wam_score_display: timeline model plus literal pins.
module tb_wam_score_display;

  localparam int R = 4;
  localparam int B = 8;
  localparam int FRAME = 4 * R;
`ifdef WAM_DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] score = '0;
  logic [3:0] lives = '0;
  logic [2:0] state = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  wam_score_display #(
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .score (score),
    .lives (lives),
    .state (state),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  // Character shown on a digit position for a given screen.
  function automatic byte hex_char(input int v);
    return (v < 10) ? byte'(48 + v) : byte'(65 + v - 10);
  endfunction

  function automatic byte screen_char(input int st, input int sc, input int lv, input int pos);
    byte tens_c;
    byte units_c;
    tens_c  = (sc >= 10) ? "1" : " ";
    units_c = hex_char(sc % 10);
    if (st == 0) begin
      case (pos)
        3: return "P";
        2: return "L";
        1: return "A";
        default: return "Y";
      endcase
    end else if (st == 1) begin
      case (pos)
        3: return "L";
        2: return hex_char(lv);
        1: return tens_c;
        default: return units_c;
      endcase
    end else if (st == 2) begin
      case (pos)
        3: return "E";
        2: return " ";
        1: return tens_c;
        default: return units_c;
      endcase
    end
    return "-";
  endfunction

  // Standard active-high segment art, inverted for the active-low pins.
  function automatic logic [6:0] char_seg(input byte c);
    logic [6:0] lit;
    case (c)
      "0": lit = 7'h3F;  "1": lit = 7'h06;  "2": lit = 7'h5B;  "3": lit = 7'h4F;
      "4": lit = 7'h66;  "5": lit = 7'h6D;  "6": lit = 7'h7D;  "7": lit = 7'h07;
      "8": lit = 7'h7F;  "9": lit = 7'h6F;  "A": lit = 7'h77;  "B": lit = 7'h7C;
      "C": lit = 7'h39;  "D": lit = 7'h5E;  "E": lit = 7'h79;  "F": lit = 7'h71;
      "P": lit = 7'h73;  "L": lit = 7'h38;  "Y": lit = 7'h6E;  "-": lit = 7'h40;
      default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

  logic [3:0] an_for_pos [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Model: mk = clock edges since reset release; frame inputs taken at edge 0
  // and at the last edge of every frame.
  int         mk        = 0;
  int         m_score   = 0;
  int         m_lives   = 0;
  int         m_state   = 0;
  int         end_entry = -1;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  bit         exp_valid = 1'b0;

  always @(posedge clk) begin
    int  pos;
    bit  hide;
    byte c;
    if (reset) begin
      mk        = 0;
      m_score   = 0;
      m_lives   = 0;
      m_state   = 0;
      end_entry = -1;
      exp_an    = 4'hF;
      exp_seg   = 7'h7F;
      exp_valid = 1'b1;
    end else begin
      pos  = (mk / R) % 4;
      hide = BLINK && (m_state == 2) && ((((mk - 1 - end_entry) / B) % 2) == 1);
      c    = screen_char(m_state, m_score, m_lives, pos);
      exp_an  = hide ? 4'hF : an_for_pos[pos];
      exp_seg = hide ? 7'h7F : char_seg(c);
      if (mk == 0 || (mk % FRAME) == FRAME - 1) begin
        if (state == 3'd2 && m_state != 2) end_entry = mk;
        m_score = score;
        m_lives = lives;
        m_state = state;
      end
      mk++;
    end
  end

  int         checks   = 0;
  int         errors   = 0;
  int         pin_req  = 0;
  int         pin_done = 0;
  logic [3:0] pin_an;
  logic [6:0] pin_seg;
  string      pin_name;

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL model t=%0t: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=1",
                 $time, an, seg, dp, exp_an, exp_seg);
      end
    end
    if (pin_req != pin_done) begin
      pin_done = pin_req;
      checks++;
      if (an !== pin_an || seg !== pin_seg) begin
        errors++;
        $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h",
                 pin_name, an, seg, pin_an, pin_seg);
      end
      checks++;
      if (exp_an !== pin_an || exp_seg !== pin_seg) begin
        errors++;
        $display("FAIL %s_model: model an=%b seg=%h, want an=%b seg=%h",
                 pin_name, exp_an, exp_seg, pin_an, pin_seg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (mk != target) begin
      if (n > 4000) begin
        $display("FAIL wait_k: edge count %0d never reached %0d", mk, target);
        $fatal(1, "wait bound expired");
      end
      tick();
      n++;
    end
  endtask

  task automatic pin(input string name, input logic [3:0] a, input logic [6:0] s);
    pin_name = name;
    pin_an   = a;
    pin_seg  = s;
    pin_req++;
  endtask

  task automatic pin_at(input int k, input string name, input logic [3:0] a, input logic [6:0] s);
    wait_k(k + 1);
    pin(name, a, s);
  endtask

  initial begin
    repeat (3) tick();
    pin("reset_blank", 4'hF, 7'h7F);
    reset = 1'b0;

    pin_at(0,  "idle_y", 4'b1110, 7'h11);
    pin_at(4,  "idle_a", 4'b1101, 7'h08);
    wait_k(6);
    state = 3'd1;
    lives = 4'd3;
    score = 4'd12;
    pin_at(8,  "idle_l_old", 4'b1011, 7'h47);
    pin_at(12, "idle_p_old", 4'b0111, 7'h0C);
    pin_at(16, "play_units2", 4'b1110, 7'h24);
    pin_at(20, "play_tens1", 4'b1101, 7'h79);
    pin_at(28, "play_l", 4'b0111, 7'h47);

    wait_k(33);
    score = 4'd7;
    lives = 4'd0;
    pin_at(48, "units7", 4'b1110, 7'h78);
    pin_at(52, "tens_blank", 4'b1101, 7'h7F);
    pin_at(56, "lives0", 4'b1011, 7'h40);

    wait_k(65);
    state = 3'd5;
    pin_at(80, "dash_d0", 4'b1110, 7'h3F);
    pin_at(92, "dash_d3", 4'b0111, 7'h3F);

    wait_k(97);
    state = 3'd2;
    score = 4'd15;
    pin_at(112, "end_units5", 4'b1110, 7'h12);
    pin_at(119, "end_tens1", 4'b1101, 7'h79);
`ifdef WAM_DISP_BLINK_EN
    pin_at(120, "blink_hidden", 4'hF, 7'h7F);
`else
    pin_at(120, "steady_blank_d2", 4'b1011, 7'h7F);
`endif
    wait_k(123);
    reset = 1'b1;
    state = 3'd0;
    score = 4'd0;
    tick();
    pin("reset_mid", 4'hF, 7'h7F);
    tick();
    reset = 1'b0;
    pin_at(0,  "post_reset_y", 4'b1110, 7'h11);
    pin_at(12, "post_reset_p", 4'b0111, 7'h0C);
    wait_k(40);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
